// File: rtl/glb_dma_pkg.sv
// Shared types and mode encodings for the GLB load-DMA address generator.
// Header fields are sized from the DMA_* constants below.
package glb_dma_pkg;

  localparam int DMA_LOOP_LEVEL          = 4;
  localparam int DMA_GLB_ADDR_WIDTH      = 22;
  localparam int DMA_MAX_RANGE_WIDTH     = 21;
  localparam int DMA_MAX_STRIDE_WIDTH    = 11;
  localparam int DMA_MAX_NUM_WORDS_WIDTH = 21;

  localparam logic [1:0] OFF       = 2'b00;
  localparam logic [1:0] NORMAL    = 2'b01;
  localparam logic [1:0] REPEAT    = 2'b10;
  localparam logic [1:0] AUTO_INCR = 2'b11;

  typedef struct packed {
    logic [DMA_MAX_RANGE_WIDTH-1:0]  range;
    logic [DMA_MAX_STRIDE_WIDTH-1:0] stride;
  } loop_ctrl_t;

  typedef struct packed {
    logic                               valid;
    logic [DMA_GLB_ADDR_WIDTH-1:0]      start_addr;
    loop_ctrl_t [DMA_LOOP_LEVEL-1:0]    iteration;
    logic [DMA_MAX_NUM_WORDS_WIDTH-1:0] num_active_words;
    logic [DMA_MAX_NUM_WORDS_WIDTH-1:0] num_inactive_words;
  } dma_ld_header_t;

endpackage

// File: rtl/glb_hdr_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module glb_hdr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/glb_ld_dma_addr_gen.sv
// GLB load-DMA address generator: queues load headers and walks an N-level
// nested loop, emitting one SRAM read request per accepted cycle.
module glb_ld_dma_addr_gen
  import glb_dma_pkg::*;
#(
  parameter int LOOP_LEVEL          = DMA_LOOP_LEVEL,
  parameter int GLB_ADDR_WIDTH      = DMA_GLB_ADDR_WIDTH,
  parameter int MAX_RANGE_WIDTH     = DMA_MAX_RANGE_WIDTH,
  parameter int MAX_STRIDE_WIDTH    = DMA_MAX_STRIDE_WIDTH,
  parameter int MAX_NUM_WORDS_WIDTH = DMA_MAX_NUM_WORDS_WIDTH,
  parameter int QUEUE_DEPTH         = 4,
  parameter int CGRA_BYTE_OFFSET    = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      dma_mode,
  input  logic                            strm_start_pulse,
  input  logic                            hdr_wr_en,
  input  dma_ld_header_t                  hdr_wr_data,
  output logic                            hdr_full,
  output logic [$clog2(QUEUE_DEPTH):0]    hdr_count,
  output logic                            rdrq_en,
  output logic [GLB_ADDR_WIDTH-1:0]       rdrq_addr,
  input  logic                            rdrq_ready,
  output logic                            busy,
  output logic                            done_pulse
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int NW    = MAX_NUM_WORDS_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD, ACTIVE, INACTIVE, DONE} state_t;

  state_t state;
  state_t state_nxt;

  dma_ld_header_t head;
  logic           fifo_empty;
  logic           head_ok;
  logic           push;
  logic           pop;
  logic           repeat_discard;
  logic [1:0]     mode_r;
  logic [1:0]     cur_mode;

  logic [GLB_ADDR_WIDTH-1:0]       start_addr_r;
  loop_ctrl_t [LOOP_LEVEL-1:0]     iter_r;
  logic [NW-1:0]                   nact_r;
  logic [NW-1:0]                   ninact_r;
  logic [NW-1:0]                   active_cnt;
  logic [NW-1:0]                   inactive_cnt;
  logic [MAX_RANGE_WIDTH-1:0]      cnt_r   [LOOP_LEVEL];
  logic [MAX_RANGE_WIDTH-1:0]      cnt_nxt [LOOP_LEVEL];
  logic [GLB_ADDR_WIDTH-1:0]       off_r   [LOOP_LEVEL];
  logic [GLB_ADDR_WIDTH-1:0]       off_nxt [LOOP_LEVEL];
  logic [GLB_ADDR_WIDTH-1:0]       off_sum;
  logic [GLB_ADDR_WIDTH-1:0]       req_addr;

  logic accept;
  logic complete;
  logic duty_en;
  logic burst_end;
  logic gap_end;

  // Mode is live while idle and frozen for the duration of a stream.
  assign cur_mode       = (state == IDLE) ? dma_mode : mode_r;
  assign push           = hdr_wr_en && hdr_wr_data.valid;
  assign repeat_discard = push && (cur_mode == REPEAT) && (hdr_count == CNT_W'(1));
  assign pop            = ((state == LOAD) && (mode_r != REPEAT)) || repeat_discard;
  assign head_ok        = !fifo_empty && head.valid;

  glb_hdr_fifo #(
    .WIDTH($bits(dma_ld_header_t)),
    .DEPTH(QUEUE_DEPTH)
  ) u_hdr_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (push),
    .wr_data(hdr_wr_data),
    .rd_en  (pop),
    .rd_data(head),
    .full   (hdr_full),
    .empty  (fifo_empty),
    .count  (hdr_count)
  );

  assign rdrq_en    = (state == ACTIVE);
  assign rdrq_addr  = rdrq_en ? req_addr : '0;
  assign busy       = (state != IDLE);
  assign done_pulse = (state == DONE);
  assign accept     = rdrq_en && rdrq_ready;

  assign duty_en   = (nact_r != '0) && (ninact_r != '0);
  assign burst_end = duty_en && (active_cnt == nact_r - NW'(1));
  assign gap_end   = (inactive_cnt == ninact_r - NW'(1));

  // Ripple-carry loop advance; a range of 0 behaves as a single iteration.
  always_comb begin
    logic carry;
    logic level_last;
    carry   = 1'b1;
    off_sum = '0;
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      cnt_nxt[i] = cnt_r[i];
      off_nxt[i] = off_r[i];
      off_sum    = off_sum + off_r[i];
      level_last = (iter_r[i].range == '0) ||
                   (cnt_r[i] == iter_r[i].range - MAX_RANGE_WIDTH'(1));
      if (carry) begin
        if (level_last) begin
          cnt_nxt[i] = '0;
          off_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt_r[i] + MAX_RANGE_WIDTH'(1);
          off_nxt[i] = off_r[i] + GLB_ADDR_WIDTH'(iter_r[i].stride[MAX_STRIDE_WIDTH-1:0]);
          carry      = 1'b0;
        end
      end
    end
    complete = carry;
  end

  assign req_addr = start_addr_r + (off_sum << CGRA_BYTE_OFFSET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (strm_start_pulse && (dma_mode != OFF) && head_ok) state_nxt = LOAD;
      LOAD:     state_nxt = ACTIVE;
      ACTIVE: begin
        if (accept) begin
          if (complete)       state_nxt = DONE;
          else if (burst_end) state_nxt = INACTIVE;
        end
      end
      INACTIVE: if (gap_end) state_nxt = ACTIVE;
      DONE:     state_nxt = ((mode_r == AUTO_INCR) && head_ok) ? LOAD : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_r       <= OFF;
      start_addr_r <= '0;
      iter_r       <= '0;
      nact_r       <= '0;
      ninact_r     <= '0;
      active_cnt   <= '0;
      inactive_cnt <= '0;
      for (int i = 0; i < LOOP_LEVEL; i++) begin
        cnt_r[i] <= '0;
        off_r[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: mode_r <= dma_mode;
        LOAD: begin
          start_addr_r <= head.start_addr;
          iter_r       <= head.iteration;
          nact_r       <= head.num_active_words;
          ninact_r     <= head.num_inactive_words;
          active_cnt   <= '0;
          inactive_cnt <= '0;
          for (int i = 0; i < LOOP_LEVEL; i++) begin
            cnt_r[i] <= '0;
            off_r[i] <= '0;
          end
        end
        ACTIVE: begin
          if (accept) begin
            for (int i = 0; i < LOOP_LEVEL; i++) begin
              cnt_r[i] <= cnt_nxt[i];
              off_r[i] <= off_nxt[i];
            end
            active_cnt <= burst_end ? '0 : active_cnt + NW'(1);
          end
        end
        INACTIVE: inactive_cnt <= gap_end ? '0 : inactive_cnt + NW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_ld_dma_addr_gen.sv
// Self-checking bench for glb_ld_dma_addr_gen: table-driven headers with an
// address scoreboard, plus hand-written timing, duty, backpressure and reset sequences.
module tb_glb_ld_dma_addr_gen;
  import glb_dma_pkg::*;

  typedef struct {
    logic [DMA_GLB_ADDR_WIDTH-1:0] start_addr;
    int r0, s0, r1, s1, nact, ninact;
    int exp_reqs;
    logic [DMA_GLB_ADDR_WIDTH-1:0] exp_last;
  } vec_t;

  logic           clk;
  logic           reset;
  logic [1:0]     dma_mode;
  logic           strm_start_pulse;
  logic           hdr_wr_en;
  dma_ld_header_t hdr_wr_data;
  logic           hdr_full;
  logic [2:0]     hdr_count;
  logic           rdrq_en;
  logic [DMA_GLB_ADDR_WIDTH-1:0] rdrq_addr;
  logic           rdrq_ready;
  logic           busy;
  logic           done_pulse;

  int vec_count = 0;
  int err_count = 0;
  int done_seen = 0;
  int req_seen  = 0;
  logic [DMA_GLB_ADDR_WIDTH-1:0] last_addr;
  logic [DMA_GLB_ADDR_WIDTH-1:0] exp_q[$];
  vec_t vecs[6];

  glb_ld_dma_addr_gen dut (
    .clk             (clk),
    .reset           (reset),
    .dma_mode        (dma_mode),
    .strm_start_pulse(strm_start_pulse),
    .hdr_wr_en       (hdr_wr_en),
    .hdr_wr_data     (hdr_wr_data),
    .hdr_full        (hdr_full),
    .hdr_count       (hdr_count),
    .rdrq_en         (rdrq_en),
    .rdrq_addr       (rdrq_addr),
    .rdrq_ready      (rdrq_ready),
    .busy            (busy),
    .done_pulse      (done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: every accepted request must match the oldest expected address.
  always @(negedge clk) begin
    if (!reset) begin
      if (done_pulse) done_seen++;
      if (rdrq_en && rdrq_ready) begin
        req_seen++;
        last_addr = rdrq_addr;
        if (exp_q.size() == 0) checkOutput("sb_unexpected_req", exp_q.size(), 1);
        else checkOutput("rdrq_addr", rdrq_addr, exp_q.pop_front());
      end
    end
  end

  function automatic dma_ld_header_t makeHeader(input logic [DMA_GLB_ADDR_WIDTH-1:0] sa,
                                                input int r0, input int s0, input int r1, input int s1,
                                                input int na, input int ni);
    dma_ld_header_t h;
    h = '0;
    h.valid                 = 1'b1;
    h.start_addr            = sa;
    h.iteration[0].range    = DMA_MAX_RANGE_WIDTH'(r0);
    h.iteration[0].stride   = DMA_MAX_STRIDE_WIDTH'(s0);
    h.iteration[1].range    = DMA_MAX_RANGE_WIDTH'(r1);
    h.iteration[1].stride   = DMA_MAX_STRIDE_WIDTH'(s1);
    h.num_active_words      = DMA_MAX_NUM_WORDS_WIDTH'(na);
    h.num_inactive_words    = DMA_MAX_NUM_WORDS_WIDTH'(ni);
    return h;
  endfunction

  // Reference model: explicit nested loops with multiplied offsets.
  task automatic modelPush(input dma_ld_header_t h);
    int rng[4];
    longint w;
    for (int l = 0; l < 4; l++)
      rng[l] = (h.iteration[l].range == 0) ? 1 : int'(h.iteration[l].range);
    for (int i3 = 0; i3 < rng[3]; i3++)
      for (int i2 = 0; i2 < rng[2]; i2++)
        for (int i1 = 0; i1 < rng[1]; i1++)
          for (int i0 = 0; i0 < rng[0]; i0++) begin
            w = longint'(i0) * longint'(h.iteration[0].stride) + longint'(i1) * longint'(h.iteration[1].stride)
              + longint'(i2) * longint'(h.iteration[2].stride) + longint'(i3) * longint'(h.iteration[3].stride);
            exp_q.push_back(DMA_GLB_ADDR_WIDTH'(longint'(h.start_addr) + (w << 1)));
          end
  endtask

  task automatic pushHeader(input dma_ld_header_t h);
    @(posedge clk); #1;
    hdr_wr_en   = 1'b1;
    hdr_wr_data = h;
    @(posedge clk); #1;
    hdr_wr_en   = 1'b0;
  endtask

  // Returns one time unit after the edge ending the pulse cycle (cycle 0).
  task automatic startStream();
    @(posedge clk); #1;
    strm_start_pulse = 1'b1;
    @(posedge clk); #1;
    strm_start_pulse = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles, output int cyc);
    cyc = -1;
    for (int c = 1; c <= max_cycles; c++) begin
      @(negedge clk);
      if (done_pulse) begin
        cyc = c;
        break;
      end
    end
    if (cyc < 0) checkOutput("done_timeout", 32'(max_cycles), 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    dma_ld_header_t h;
    int cyc, d0, r0;
    h = makeHeader(v.start_addr, v.r0, v.s0, v.r1, v.s1, v.nact, v.ninact);
    dma_mode = NORMAL;
    pushHeader(h);
    checkOutput("vec_hdr_count_push", hdr_count, 1);
    modelPush(h);
    d0 = done_seen;
    r0 = req_seen;
    startStream();
    waitDone(200, cyc);
    @(negedge clk);
    checkOutput("vec_req_count", req_seen - r0, v.exp_reqs);
    checkOutput("vec_last_addr", last_addr, v.exp_last);
    checkOutput("vec_done_count", done_seen - d0, 1);
    checkOutput("vec_busy_end", busy, 0);
    checkOutput("vec_hdr_count_end", hdr_count, 0);
    checkOutput("vec_sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dma_ld_header_t h;
    int cyc, d0, r0;
    logic [11:0] duty_pat;

    vecs[0] = '{22'h000100, 4, 1, 0, 0, 0, 0, 4, 22'h000106};
    vecs[1] = '{22'h000000, 2, 1, 3, 8, 0, 0, 6, 22'h000022};
    vecs[2] = '{22'h000200, 0, 5, 0, 0, 0, 0, 1, 22'h000200};
    vecs[3] = '{22'h3FFFFE, 3, 1, 0, 0, 0, 0, 3, 22'h000002};
    vecs[4] = '{22'h000040, 6, 2, 0, 0, 2, 3, 6, 22'h000054};
    vecs[5] = '{22'h000000, 5, 3, 0, 0, 3, 0, 5, 22'h000018};

    reset = 1'b1;
    dma_mode = NORMAL;
    strm_start_pulse = 1'b0;
    hdr_wr_en = 1'b0;
    hdr_wr_data = '0;
    rdrq_ready = 1'b1;
    #12;
    checkOutput("rst_rdrq_en", rdrq_en, 0);
    checkOutput("rst_rdrq_addr", rdrq_addr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done_pulse, 0);
    checkOutput("rst_hdr_full", hdr_full, 0);
    checkOutput("rst_hdr_count", hdr_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Invalid header is dropped, and a start on an empty queue is ignored.
    h = makeHeader(22'h123, 4, 1, 0, 0, 0, 0);
    h.valid = 1'b0;
    pushHeader(h);
    checkOutput("invalid_hdr_count", hdr_count, 0);
    startStream();
    @(negedge clk);
    checkOutput("empty_start_busy", busy, 0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Cycle-exact latency of the first test-plan header.
    h = makeHeader(22'h100, 4, 1, 0, 0, 0, 0);
    pushHeader(h);
    modelPush(h);
    startStream();
    @(negedge clk);
    checkOutput("t1_count_c1", hdr_count, 1);
    checkOutput("t1_en_c1", rdrq_en, 0);
    @(negedge clk);
    checkOutput("t1_count_c2", hdr_count, 0);
    checkOutput("t1_en_c2", rdrq_en, 1);
    waitDone(20, cyc);
    checkOutput("t1_done_cycle", cyc + 2, 6);

    // Duty cycle pattern 11 000 11 000 11 then done.
    h = makeHeader(22'h0, 6, 1, 0, 0, 2, 3);
    pushHeader(h);
    modelPush(h);
    startStream();
    @(negedge clk);
    checkOutput("duty_en_c1", rdrq_en, 0);
    duty_pat = 12'b110001100011;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checkOutput("duty_en", rdrq_en, duty_pat[11-c]);
      checkOutput("duty_no_early_done", done_pulse, 0);
    end
    @(negedge clk);
    checkOutput("duty_done", done_pulse, 1);
    @(negedge clk);
    checkOutput("duty_busy_end", busy, 0);

    // Backpressure: five stalled cycles mid-stream.
    h = makeHeader(22'h80, 10, 2, 0, 0, 0, 0);
    pushHeader(h);
    modelPush(h);
    r0 = req_seen;
    startStream();
    repeat (3) @(posedge clk);
    #1 rdrq_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_en_held", rdrq_en, 1);
      if (exp_q.size() > 0) checkOutput("bp_addr_held", rdrq_addr, exp_q[0]);
      else checkOutput("bp_sb_size", exp_q.size(), 1);
    end
    @(posedge clk); #1 rdrq_ready = 1'b1;
    waitDone(60, cyc);
    @(negedge clk);
    checkOutput("bp_req_count", req_seen - r0, 10);
    checkOutput("bp_sb_drained", exp_q.size(), 0);

    // REPEAT re-runs the head; a push at occupancy 1 replaces it.
    dma_mode = REPEAT;
    h = makeHeader(22'h300, 2, 1, 0, 0, 0, 0);
    pushHeader(h);
    for (int k = 0; k < 2; k++) begin
      modelPush(h);
      startStream();
      waitDone(20, cyc);
      @(negedge clk);
      checkOutput("rep_count_kept", hdr_count, 1);
    end
    h = makeHeader(22'h380, 2, 1, 0, 0, 0, 0);
    pushHeader(h);
    checkOutput("rep_replace_count", hdr_count, 1);
    modelPush(h);
    startStream();
    waitDone(20, cyc);
    dma_mode = NORMAL;
    modelPush(h);
    startStream();
    waitDone(20, cyc);
    @(negedge clk);
    checkOutput("rep_normal_pop", hdr_count, 0);
    checkOutput("rep_sb_drained", exp_q.size(), 0);

    // AUTO_INCR: three headers chained from one start.
    for (int k = 0; k < 3; k++) begin
      h = makeHeader(22'h400 + 22'(k * 'h100), 2, 1, 0, 0, 0, 0);
      pushHeader(h);
      modelPush(h);
    end
    dma_mode = AUTO_INCR;
    d0 = done_seen;
    startStream();
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      checkOutput("ai_busy", busy, (c <= 12) ? 1 : 0);
      checkOutput("ai_done", done_pulse, ((c % 4 == 0) && (c <= 12)) ? 1 : 0);
    end
    checkOutput("ai_done_count", done_seen - d0, 3);
    checkOutput("ai_hdr_count", hdr_count, 0);
    checkOutput("ai_sb_drained", exp_q.size(), 0);

    // Full queue: fifth push is dropped and never streamed.
    dma_mode = NORMAL;
    for (int k = 0; k < 4; k++) begin
      h = makeHeader(22'h1000 + 22'(k * 'h100), 1, 0, 0, 0, 0, 0);
      pushHeader(h);
      modelPush(h);
    end
    checkOutput("full_count4", hdr_count, 4);
    checkOutput("full_flag", hdr_full, 1);
    pushHeader(makeHeader(22'h2000, 1, 0, 0, 0, 0, 0));
    checkOutput("full_drop_count", hdr_count, 4);
    dma_mode = AUTO_INCR;
    d0 = done_seen;
    startStream();
    repeat (20) @(negedge clk);
    checkOutput("full_done_count", done_seen - d0, 4);
    checkOutput("full_hdr_count_end", hdr_count, 0);
    checkOutput("full_flag_end", hdr_full, 0);
    checkOutput("full_sb_drained", exp_q.size(), 0);

    // Asynchronous reset mid-ACTIVE.
    dma_mode = NORMAL;
    h = makeHeader(22'h40, 16, 1, 0, 0, 0, 0);
    pushHeader(h);
    pushHeader(makeHeader(22'h50, 16, 1, 0, 0, 0, 0));
    modelPush(h);
    startStream();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("arst_rdrq_en", rdrq_en, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_hdr_count", hdr_count, 0);
    checkOutput("arst_rdrq_addr", rdrq_addr, 0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    startStream();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("post_rst_busy", busy, 0);
      checkOutput("post_rst_en", rdrq_en, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/glb_ld_dma_addr_gen.md
Name: glb_ld_dma_addr_gen

Overview:
- Parametrised successor to the fixed 4-level GLB load-DMA descriptor scheme.
- Buffers load headers in a queue and walks an N-level nested loop to emit one read request per accepted cycle.
- Supports active/inactive duty cycling and OFF, NORMAL, REPEAT and AUTO_INCR modes.
- Sits between the per-tile config registers and the tile's SRAM read-request path (rdrq).

Parameters:
- LOOP_LEVEL, 4, number of nested loop levels (1..8).
- GLB_ADDR_WIDTH, 22, byte address width.
- MAX_RANGE_WIDTH, 21, per-level range width.
- MAX_STRIDE_WIDTH, 11, per-level stride width, in CGRA words.
- MAX_NUM_WORDS_WIDTH, 21, active/inactive word counter width.
- QUEUE_DEPTH, 4, header queue entries (power of 2, at least 2).
- CGRA_BYTE_OFFSET, 1, word-to-byte shift.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- dma_mode  in  2  OFF=00, NORMAL=01, REPEAT=10, AUTO_INCR=11; sampled only in IDLE.
- strm_start_pulse  in  1  one-cycle start request.
- hdr_wr_en  in  1  push a header into the queue.
- hdr_wr_data  in  dma_ld_header_t  header: valid, start_addr, iteration[LOOP_LEVEL], num_active_words, num_inactive_words.
- hdr_full  out  1  queue is full.
- hdr_count  out  $clog2(QUEUE_DEPTH)+1  current queue occupancy.
- rdrq_en  out  1  read request valid.
- rdrq_addr  out  GLB_ADDR_WIDTH  read request byte address.
- rdrq_ready  in  1  downstream accepts the request.
- busy  out  1  state is not IDLE.
- done_pulse  out  1  one-cycle pulse when a header completes.

Behaviour:
- Reset (async): queue empty, state IDLE, all counters 0. Outputs: rdrq_en=0, rdrq_addr=0, busy=0, done_pulse=0, hdr_full=0, hdr_count=0.
- Queue:
  - hdr_wr_en while full: write dropped, contents unchanged.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - Headers with valid=0 are dropped on write.
- States: IDLE, LOAD, ACTIVE, INACTIVE, DONE.
- IDLE -> LOAD on strm_start_pulse when dma_mode!=OFF and the queue is non-empty.
  - If the queue is empty, or mode is OFF, the start is ignored.
- LOAD (1 cycle): copy the head header into working registers; clear all iteration counters and offsets.
  - Head is popped here in NORMAL and AUTO_INCR modes; REPEAT does not pop.
  - First rdrq_en is asserted 2 cycles after the start pulse.
- ACTIVE:
  - rdrq_en=1, rdrq_addr = start_addr + (sum of per-level offsets << CGRA_BYTE_OFFSET), modulo 2^GLB_ADDR_WIDTH.
  - Offsets are kept incrementally per level (no multipliers).
  - A request is accepted when rdrq_en and rdrq_ready are both high. Only an accepted request advances the counters; while rdrq_ready=0, rdrq_addr is held stable.
- Loop advance on each accepted request:
  - Level 0 increments. On wrap it resets to 0 and carries to the next level.
  - range=0 is treated as 1.
  - Completion = all levels wrap on the same accepted request.
- Duty cycling:
  - If num_active_words!=0 and num_inactive_words!=0: after num_active_words accepted requests, go to INACTIVE for num_inactive_words cycles (rdrq_en=0, free-running, not gated by rdrq_ready), then return to ACTIVE.
  - If either field is 0: continuous ACTIVE.
- Completion (takes priority over an INACTIVE transition) -> DONE.
- DONE (1 cycle): done_pulse=1, then:
  - AUTO_INCR with queue non-empty -> LOAD.
  - Otherwise -> IDLE.
- REPEAT: each new start re-runs the same head header. The head is discarded only when a new header is written while the queue holds 1 entry in REPEAT mode.
- strm_start_pulse while busy is ignored.
- Reset mid-operation aborts the stream immediately and empties the queue.

Decomposition:
- Package glb_dma_pkg holds:
  - loop_ctrl_t and dma_ld_header_t, parametrised on LOOP_LEVEL and the width parameters;
  - mode constants OFF, NORMAL, REPEAT, AUTO_INCR.
- Sub-module glb_hdr_fifo: generic synchronous FIFO (WIDTH, DEPTH) with full, empty and count outputs.
- The loop/offset engine stays inline in glb_ld_dma_addr_gen.

Test Plan:
- NORMAL, start_addr=0x100, level0 range=4 stride=1, others range=0; start -> rdrq_addr 0x100, 0x102, 0x104, 0x106 on cycles 2-5; done_pulse on cycle 6; hdr_count 1->0.
- Two levels: range0=2 stride0=1, range1=3 stride1=8, start_addr=0 -> addr sequence 0x0, 0x2, 0x10, 0x12, 0x20, 0x22; exactly 6 requests.
- num_active=2, num_inactive=3, 6 total words -> rdrq_en pattern 11 000 11 000 11, then done_pulse.
- Backpressure: hold rdrq_ready=0 for 5 cycles mid-stream -> rdrq_addr held stable, no request lost or duplicated.
- AUTO_INCR with 3 queued headers, single start -> 3 done_pulses back-to-back (DONE->LOAD), busy stays high throughout; 5th push into the full 4-deep queue is dropped.
- Reset asserted mid-ACTIVE -> rdrq_en=0, busy=0 and hdr_count=0 asynchronously; a later start with an empty queue stays in IDLE.
